// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // W is a power of two, so masking with W-1 gives the modulo-W wrap.
    function automatic logic [31:0] ptr_inc(input logic [31:0] p, input int unsigned w);
        return (p + 32'd1) & (w - 32'd1);
    endfunction

endpackage

// File: rtl/rr_arb_s.sv
// Rotating first-set-bit selector: finds the first set bit of x_i at index >= pos_i,
// wrapping modulo W.
module s #(
    parameter int W = 8
) (
    input  logic [W-1:0]         x_i,
    input  logic [$clog2(W)-1:0] pos_i,
    output logic                 any_o,
    output logic [W-1:0]         y_o,
    output logic [$clog2(W)-1:0] y_enc_o
);

    localparam int LW = $clog2(W);

    logic [LW-1:0] idx;

    always_comb begin
        idx     = '0;
        any_o   = 1'b0;
        y_o     = '0;
        y_enc_o = '0;
        for (int i = 0; i < W; i++) begin
            idx = pos_i + LW'(i);
            if (!any_o && x_i[idx]) begin
                any_o   = 1'b1;
                y_enc_o = idx;
            end
        end
        if (any_o) begin
            y_o[y_enc_o] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb.sv
// Registered round-robin arbiter with sticky handshaked grant and rotating priority pointer.
// Optional RR_ARB_LOCK_EN adds lock_i, which keeps priority on the granted requester on accept.
//
// state | meaning
// IDLE  | no grant outstanding, gnt_vld_o = 0
// GRANT | grant held stable until gnt_rdy_i accepts it
module rr_arb
    import rr_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic [W-1:0]         req_i,
    input  logic                 gnt_rdy_i,
`ifdef RR_ARB_LOCK_EN
    input  logic                 lock_i,
`endif
    output logic                 gnt_vld_o,
    output logic [W-1:0]         gnt_o,
    output logic [$clog2(W)-1:0] gnt_enc_o,
    output logic [$clog2(W)-1:0] ptr_o
);

    localparam int LW = $clog2(W);

    state_t        state;
    logic          accept;
    logic          hold_ptr;
    logic [LW-1:0] ptr_next;
    logic [LW-1:0] search_pos;
    logic          sel_any;
    logic [W-1:0]  sel_y;
    logic [LW-1:0] sel_enc;

    assign accept = (state == GRANT) && gnt_rdy_i;

`ifdef RR_ARB_LOCK_EN
    assign hold_ptr = lock_i;
`else
    assign hold_ptr = 1'b0;
`endif

    assign ptr_next = hold_ptr ? gnt_enc_o : LW'(ptr_inc(32'(gnt_enc_o), W));

    // On accept the follow-on grant is searched from the updated pointer in the same cycle.
    assign search_pos = accept ? ptr_next : ptr_o;

    s #(.W(W)) u_sel (
        .x_i     (req_i),
        .pos_i   (search_pos),
        .any_o   (sel_any),
        .y_o     (sel_y),
        .y_enc_o (sel_enc)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            ptr_o     <= '0;
            gnt_vld_o <= 1'b0;
            gnt_o     <= '0;
            gnt_enc_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        state     <= GRANT;
                        gnt_vld_o <= 1'b1;
                        gnt_o     <= sel_y;
                        gnt_enc_o <= sel_enc;
                    end
                end
                GRANT: begin
                    if (gnt_rdy_i) begin
                        ptr_o <= ptr_next;
                        if (sel_any) begin
                            gnt_o     <= sel_y;
                            gnt_enc_o <= sel_enc;
                        end else begin
                            state     <= IDLE;
                            gnt_vld_o <= 1'b0;
                            gnt_o     <= '0;
                            gnt_enc_o <= '0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_vld_o <= 1'b0;
                    gnt_o     <= '0;
                    gnt_enc_o <= '0;
                end
            endcase
        end
    end

endmodule
